// File: rtl/led_arbiter.sv
// Round-robin arbiter sharing one board LED between N_REQ blink sources, with a minimum dwell per grant.
// Optional build macro LED_ARB_PREEMPT_EN gives requester 0 priority and lets it preempt other owners.
module led_arbiter #(
  parameter int N_REQ       = 4,
  parameter int PRESCALE_W  = 16,
  parameter int DWELL_TICKS = 8,
  parameter int RATE_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*RATE_W-1:0] rate,
  output logic [N_REQ-1:0]        grant,
  output logic                    led,
  output logic                    busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t                  state_q, state_d;
  logic [PRESCALE_W-1:0]   presc_q;
  logic                    tick;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [N_REQ-1:0]        grant_q, grant_d;
  logic                    led_q, led_d;
  logic                    busy_q, busy_d;
  logic [RATE_W-1:0]       rate_q, rate_d;
  logic [RATE_W-1:0]       blink_q, blink_d;
  logic [7:0]              dwell_q, dwell_d;
  logic [RATE_W-1:0]       rate_arr [N_REQ];
  logic [IDX_W-1:0]        sel, idx_v;
  logic                    sel_vld;
  logic                    exit_now;
`ifdef LED_ARB_PREEMPT_EN
  logic                    req0_q;
`endif

  for (genvar i = 0; i < N_REQ; i++) begin : g_rate
    assign rate_arr[i] = rate[i*RATE_W +: RATE_W];
  end

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int k);
    return IDX_W'((int'(base) + k) % N_REQ);
  endfunction

  assign tick = &presc_q;

  // Descending scan so the nearest set bit after last_q overrides farther ones.
  always_comb begin
    sel     = last_q;
    sel_vld = 1'b0;
    idx_v   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx_v = rr_idx(last_q, k);
      if (req[idx_v]) begin
        sel     = idx_v;
        sel_vld = 1'b1;
      end
    end
`ifdef LED_ARB_PREEMPT_EN
    if (req[0]) begin
      sel     = '0;
      sel_vld = 1'b1;
    end
`endif
  end

  // An owner drop and a dwell expiry coincide harmlessly: both just exit to GAP.
  always_comb begin
    exit_now = !req[last_q] ||
               ((dwell_q == 8'(DWELL_TICKS)) && (|(req & ~grant_q)));
`ifdef LED_ARB_PREEMPT_EN
    if ((last_q != '0) && req[0] && !req0_q) exit_now = 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    led_d   = led_q;
    busy_d  = busy_q;
    rate_d  = rate_q;
    blink_d = blink_q;
    dwell_d = dwell_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d = GRANT;
          last_d  = sel;
          grant_d = N_REQ'(1) << sel;
          led_d   = 1'b1;
          busy_d  = 1'b1;
          rate_d  = rate_arr[sel];
          blink_d = '0;
          dwell_d = '0;
        end
      end
      GRANT: begin
        if (exit_now) begin
          state_d = GAP;
          grant_d = '0;
          led_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (tick) begin
          if (rate_q != '0) begin
            if (blink_q + RATE_W'(1) == rate_q) begin
              led_d   = ~led_q;
              blink_d = '0;
            end else begin
              blink_d = blink_q + RATE_W'(1);
            end
          end else begin
            led_d = 1'b1;
          end
          if (dwell_q != 8'(DWELL_TICKS)) dwell_d = dwell_q + 8'd1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      grant_q <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      rate_q  <= '0;
      blink_q <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_q + PRESCALE_W'(1);
      last_q  <= last_d;
      grant_q <= grant_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      rate_q  <= rate_d;
      blink_q <= blink_d;
      dwell_q <= dwell_d;
    end
  end

`ifdef LED_ARB_PREEMPT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req0_q <= 1'b0;
    else        req0_q <= req[0];
  end
`endif

  assign grant = grant_q;
  assign led   = led_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter with a 4-cycle tick (PRESCALE_W=2) and a 2-tick dwell.
module tb_led_arbiter;
  localparam int N_REQ       = 4;
  localparam int PRESCALE_W  = 2;
  localparam int DWELL_TICKS = 2;
  localparam int RATE_W      = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] rate;
  logic [3:0]  grant;
  logic        led;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  led_arbiter #(
    .N_REQ(N_REQ), .PRESCALE_W(PRESCALE_W), .DWELL_TICKS(DWELL_TICKS), .RATE_W(RATE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rate(rate),
    .grant(grant), .led(led), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Release lands on a falling edge, so cyc counts rising edges after release.
  task automatic apply_reset(input logic [3:0] r, input logic [15:0] rt);
    rst_n = 1'b0;
    req   = '0;
    rate  = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    req   = r;
    rate  = rt;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    rate  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    total++;
    if ({grant, led, busy} !== 6'b0000_00) begin
      bad++;
      $display("FAIL reset_hold got=%b exp=%b", {grant, led, busy}, 6'b0000_00);
    end
    apply_reset(4'b0000, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({grant, led, busy} !== 6'b0000_00) begin
        bad++;
        $display("FAIL idle_noreq cyc=%0d got=%b exp=%b", cyc, {grant, led, busy}, 6'b0000_00);
      end
    end
  endtask

  task automatic test_solid();
    apply_reset(4'b0001, 16'h0000);
    total++;
    if (grant !== 4'b0000) begin
      bad++;
      $display("FAIL solid_pre got=%b exp=%b", grant, 4'b0000);
    end
    for (int i = 0; i < 101; i++) begin
      step();
      total++;
      if ({grant, led, busy} !== 6'b0001_11) begin
        bad++;
        $display("FAIL solid cyc=%0d got=%b exp=%b", cyc, {grant, led, busy}, 6'b0001_11);
      end
    end
  endtask

  task automatic test_blink();
    logic exp_led;
    apply_reset(4'b0000, 16'h0020);
    for (int i = 0; i < 3; i++) step();
    req = 4'b0010;
    // Grant lands on the edge where the prescaler wraps to 0: toggles every 8 clk.
    for (int i = 0; i < 32; i++) begin
      step();
      exp_led = (((cyc - 4) / 8) % 2) == 0;
      total++;
      if ({grant, led, busy} !== {4'b0010, exp_led, 1'b1}) begin
        bad++;
        $display("FAIL blink cyc=%0d got=%b exp=%b", cyc, {grant, led, busy}, {4'b0010, exp_led, 1'b1});
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    int m;
    int k;
    apply_reset(4'b0101, 16'h0000);
    for (int i = 0; i < 40; i++) begin
      step();
      if (cyc <= 8) begin
        exp_g = 4'b0001;
      end else begin
        m = (cyc - 9) % 8;
        k = (cyc - 9) / 8;
        if (m < 2) exp_g = 4'b0000;
`ifdef LED_ARB_PREEMPT_EN
        else exp_g = 4'b0001;
`else
        else if (k % 2 == 0) exp_g = 4'b0100;
        else exp_g = 4'b0001;
`endif
      end
      total++;
      if ({grant, led, busy} !== {exp_g, exp_g != 4'b0000, exp_g != 4'b0000}) begin
        bad++;
        $display("FAIL rr cyc=%0d got=%b exp=%b", cyc, {grant, led, busy},
                 {exp_g, exp_g != 4'b0000, exp_g != 4'b0000});
      end
    end
  endtask

  task automatic test_drop();
    apply_reset(4'b0100, 16'h0200);
    for (int i = 0; i < 9; i++) begin
      step();
      if (cyc == 1) begin
        total++;
        if ({grant, led, busy} !== 6'b0100_11) begin
          bad++;
          $display("FAIL drop_grant got=%b exp=%b", {grant, led, busy}, 6'b0100_11);
        end
      end
    end
    total++;
    if ({grant, led, busy} !== 6'b0100_01) begin
      bad++;
      $display("FAIL drop_midblink got=%b exp=%b", {grant, led, busy}, 6'b0100_01);
    end
    req = 4'b0010;
    step();
    total++;
    if ({grant, led, busy} !== 6'b0000_00) begin
      bad++;
      $display("FAIL drop_gap got=%b exp=%b", {grant, led, busy}, 6'b0000_00);
    end
    step();
    total++;
    if ({grant, led, busy} !== 6'b0000_00) begin
      bad++;
      $display("FAIL drop_idle got=%b exp=%b", {grant, led, busy}, 6'b0000_00);
    end
    step();
    total++;
    if ({grant, led, busy} !== 6'b0010_11) begin
      bad++;
      $display("FAIL drop_next got=%b exp=%b", {grant, led, busy}, 6'b0010_11);
    end
  endtask

  task automatic test_async_reset();
    apply_reset(4'b0100, 16'h0000);
    step();
    total++;
    if (grant !== 4'b0100) begin
      bad++;
      $display("FAIL ares_pre got=%b exp=%b", grant, 4'b0100);
    end
    for (int i = 0; i < 4; i++) step();
    #2;
    rst_n = 1'b0;
    req   = 4'b1111;
    #1;
    total++;
    if ({grant, led, busy} !== 6'b0000_00) begin
      bad++;
      $display("FAIL ares_clear got=%b exp=%b", {grant, led, busy}, 6'b0000_00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    step();
    total++;
    if ({grant, led, busy} !== 6'b0001_11) begin
      bad++;
      $display("FAIL ares_first got=%b exp=%b", {grant, led, busy}, 6'b0001_11);
    end
  endtask

  task automatic test_dwell_preempt();
    logic [3:0] exp_g;
    apply_reset(4'b0100, 16'h0000);
    step();
    total++;
    if (grant !== 4'b0100) begin
      bad++;
      $display("FAIL dwell_owner got=%b exp=%b", grant, 4'b0100);
    end
    req = 4'b0101;
    for (int i = 0; i < 11; i++) begin
      step();
`ifdef LED_ARB_PREEMPT_EN
      if (cyc <= 3) exp_g = 4'b0000;
      else          exp_g = 4'b0001;
`else
      if (cyc <= 8)       exp_g = 4'b0100;
      else if (cyc <= 10) exp_g = 4'b0000;
      else                exp_g = 4'b0001;
`endif
      total++;
      if ({grant, led, busy} !== {exp_g, exp_g != 4'b0000, exp_g != 4'b0000}) begin
        bad++;
        $display("FAIL dwell cyc=%0d got=%b exp=%b", cyc, {grant, led, busy},
                 {exp_g, exp_g != 4'b0000, exp_g != 4'b0000});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    rate  = '0;
    test_reset();
    test_solid();
    test_blink();
    test_round_robin();
    test_drop();
    test_async_reset();
    test_dwell_preempt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
